// File: rtl/philo_pkg.sv
// Shared definitions for the dining-philosophers ring: per-philosopher state encoding.
package philo_pkg;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    THINKING = 2'd0,
    READING  = 2'd1,
    EATING   = 2'd2,
    HUNGRY   = 2'd3
  } state_t;

  function automatic logic is_state(logic [ST_W-1:0] s, state_t v);
    return s == v;
  endfunction

endpackage

// File: rtl/philo_wait_ctr.sv
// Per-philosopher consecutive-HUNGRY counter, saturating at MAX_WAIT, with a starvation hit strobe.
module philo_wait_ctr #(
  parameter int unsigned CW       = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  input  logic hungry,
  output logic hit_c
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_PRE = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (!hungry)
        cnt <= '0;
      else if (cnt < CNT_MAX)
        cnt <= cnt + CW'(1);
    end
  end

  // Fires on the sample that brings the run to MAX_WAIT and on every saturated sample after.
  assign hit_c = en & ~clr & hungry & (cnt >= CNT_PRE);

endmodule

// File: rtl/philo_monitor.sv
// Passive safety/liveness observer of the philosopher ring: mutex breaches, starvation,
// and the concurrent-eater high-water mark, all with two-cycle latency.
module philo_monitor
  import philo_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CW       = 4,
  parameter int unsigned IW       = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ST_W*N-1:0] st,
  input  logic              enable,
  input  logic              clear,
  output logic              mutex_err,
  output logic [IW-1:0]     mutex_idx,
  output logic              starve_err,
  output logic [IW-1:0]     starve_idx,
  output logic [IW:0]       eaters,
  output logic [IW:0]       eaters_max
);

  localparam int unsigned EW = IW + 1;

  logic [ST_W*N-1:0] st_q;
  logic [N-1:0]      eat_c;
  logic [N-1:0]      hungry_c;
  logic [N-1:0]      pair_c;
  logic [N-1:0]      hit_c;
  logic [IW-1:0]     pair_idx_c;
  logic [IW-1:0]     hit_idx_c;
  logic [EW-1:0]     eaters_c;

  for (genvar i = 0; i < N; i++) begin : g_ph
    assign eat_c[i]    = is_state(st_q[ST_W*i +: ST_W], EATING);
    assign hungry_c[i] = is_state(st_q[ST_W*i +: ST_W], HUNGRY);
    assign pair_c[i]   = eat_c[i] & eat_c[(i + 1) % N];

    philo_wait_ctr #(
      .CW       (CW),
      .MAX_WAIT (MAX_WAIT)
    ) u_wait (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (enable),
      .clr     (clear),
      .hungry  (hungry_c[i]),
      .hit_c   (hit_c[i])
    );
  end

  // Lowest-index encoders for first breach, plus eater popcount.
  always_comb begin
    pair_idx_c = '0;
    hit_idx_c  = '0;
    eaters_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pair_c[i]) pair_idx_c = IW'(i);
      if (hit_c[i])  hit_idx_c  = IW'(i);
    end
    for (int i = 0; i < N; i++)
      eaters_c = eaters_c + EW'(eat_c[i]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= '0;
    end else if (enable) begin
      st_q <= st;
    end
  end

  // Clear wins over checking; the eater count itself keeps tracking the sampled ring.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mutex_err  <= 1'b0;
      mutex_idx  <= '0;
      starve_err <= 1'b0;
      starve_idx <= '0;
      eaters     <= '0;
      eaters_max <= '0;
    end else if (clear) begin
      mutex_err  <= 1'b0;
      mutex_idx  <= '0;
      starve_err <= 1'b0;
      starve_idx <= '0;
      eaters_max <= '0;
      if (enable) eaters <= eaters_c;
    end else if (enable) begin
      eaters <= eaters_c;
      if (eaters_c > eaters_max) eaters_max <= eaters_c;
      if (!mutex_err && (|pair_c)) begin
        mutex_err <= 1'b1;
        mutex_idx <= pair_idx_c;
      end
      if (!starve_err && (|hit_c)) begin
        starve_err <= 1'b1;
        starve_idx <= hit_idx_c;
      end
    end
  end

endmodule

// File: tb/tb_philo_monitor.sv
// Self-checking bench for philo_monitor: directed scenarios then randomized traffic,
// compared every cycle against a run-length based reference model.
module tb_philo_monitor;

  localparam int N        = 4;
  localparam int MAX_WAIT = 3;
  localparam int CW       = 2;
  localparam int IW       = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [2*N-1:0]    st;
  logic              enable;
  logic              clear;
  logic              mutex_err;
  logic [IW-1:0]     mutex_idx;
  logic              starve_err;
  logic [IW-1:0]     starve_idx;
  logic [IW:0]       eaters;
  logic [IW:0]       eaters_max;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: sampled ring, hungry run lengths, flags.
  int m_q   [N];
  int m_run [N];
  int m_merr, m_midx, m_serr, m_sidx, m_eat, m_emax;

  philo_monitor #(.N(N), .MAX_WAIT(MAX_WAIT), .CW(CW), .IW(IW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .st         (st),
    .enable     (enable),
    .clear      (clear),
    .mutex_err  (mutex_err),
    .mutex_idx  (mutex_idx),
    .starve_err (starve_err),
    .starve_idx (starve_idx),
    .eaters     (eaters),
    .eaters_max (eaters_max)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_q[i]   = 0;
      m_run[i] = 0;
    end
    m_merr = 0; m_midx = 0; m_serr = 0; m_sidx = 0; m_eat = 0; m_emax = 0;
  endtask

  // One clock edge of the specified behaviour, using the ring sampled on the previous edge.
  task automatic model_edge(input logic [2*N-1:0] s, input bit en, input bit clr);
    int ne;
    ne = 0;
    for (int i = 0; i < N; i++) if (m_q[i] == 2) ne++;
    if (clr) begin
      m_merr = 0; m_midx = 0; m_serr = 0; m_sidx = 0; m_emax = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      if (en) m_eat = ne;
    end else if (en) begin
      for (int i = 0; i < N; i++) m_run[i] = (m_q[i] == 3) ? m_run[i] + 1 : 0;
      m_eat = ne;
      if (ne > m_emax) m_emax = ne;
      for (int i = 0; i < N; i++)
        if (m_merr == 0 && m_q[i] == 2 && m_q[(i + 1) % N] == 2) begin
          m_merr = 1; m_midx = i;
        end
      for (int i = 0; i < N; i++)
        if (m_serr == 0 && m_run[i] >= MAX_WAIT) begin
          m_serr = 1; m_sidx = i;
        end
    end
    if (en) for (int i = 0; i < N; i++) m_q[i] = int'(s[2*i +: 2]);
  endtask

  task automatic compare_all();
    check("mutex_err",  32'(mutex_err),  32'(m_merr));
    check("mutex_idx",  32'(mutex_idx),  32'(m_midx));
    check("starve_err", 32'(starve_err), 32'(m_serr));
    check("starve_idx", 32'(starve_idx), 32'(m_sidx));
    check("eaters",     32'(eaters),     32'(m_eat));
    check("eaters_max", 32'(eaters_max), 32'(m_emax));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge(st, enable, clear);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [2*N-1:0] s, input bit en, input bit clr, input int n);
    st = s; enable = en; clear = clr;
    repeat (n) step();
  endtask

  // Assert reset away from the edge, let it span some clocks with random st, release on negedge.
  task automatic reset_pulse(input int cycles);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) begin
      st = 8'($urandom);
      @(posedge clock);
      #1;
      compare_all();
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; st = '0; enable = 1'b1; clear = 1'b0;
    model_reset();

    // 1: reset with random ring, then idle ring
    reset_pulse(4);
    drive(8'h00, 1, 0, 10);
    check("t1_mutex_err", 32'(mutex_err), 0);
    check("t1_eaters_max", 32'(eaters_max), 0);

    // 2: ph1+ph2 eating for one sample
    drive(8'h28, 1, 0, 1);
    drive(8'h00, 1, 0, 1);
    check("t2_mutex_err", 32'(mutex_err), 1);
    check("t2_mutex_idx", 32'(mutex_idx), 1);
    check("t2_eaters", 32'(eaters), 2);
    check("t2_eaters_max", 32'(eaters_max), 2);
    drive(8'h00, 1, 0, 3);
    check("t2_sticky", 32'(mutex_err), 1);

    // 3: wrap-around pair ph3+ph0
    drive(8'h00, 1, 1, 1);
    drive(8'h82, 1, 0, 1);
    drive(8'h00, 1, 0, 1);
    check("t3_mutex_idx", 32'(mutex_idx), 3);

    // 4: broken hungry run does not count
    drive(8'h00, 1, 1, 1);
    drive(8'h30, 1, 0, 2);
    drive(8'h00, 1, 0, 1);
    drive(8'h30, 1, 0, 3);
    check("t4_not_yet", 32'(starve_err), 0);
    drive(8'h00, 1, 0, 1);
    check("t4_starve_err", 32'(starve_err), 1);
    check("t4_starve_idx", 32'(starve_idx), 2);

    // 5: simultaneous hungry ph1/ph3 with enable dropped mid-run
    drive(8'h00, 1, 1, 1);
    drive(8'hCC, 1, 0, 3);
    drive(8'hCC, 0, 0, 2);
    check("t5_frozen", 32'(starve_err), 0);
    drive(8'hCC, 1, 0, 1);
    check("t5_starve_err", 32'(starve_err), 1);
    check("t5_starve_idx", 32'(starve_idx), 1);

    // 6: clear with both flags set, then reset during a hungry run
    drive(8'h0A, 1, 0, 1);
    drive(8'h00, 1, 0, 2);
    check("t6_both", 32'(mutex_err & starve_err), 1);
    drive(8'h00, 1, 1, 1);
    check("t6_clr_mutex", 32'(mutex_err), 0);
    check("t6_clr_starve", 32'(starve_err), 0);
    check("t6_clr_emax", 32'(eaters_max), 0);
    drive(8'h03, 1, 0, 2);
    reset_pulse(0);
    drive(8'h03, 1, 0, 3);
    check("t6_restart", 32'(starve_err), 0);
    drive(8'h03, 1, 0, 1);
    check("t6_starve_idx", 32'(starve_idx), 0);
    check("t6_starve_err", 32'(starve_err), 1);

    // Randomized traffic with sticky states, enable gaps, clears and resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 1) == 0) st = 8'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 149) == 0)
        reset_pulse($urandom_range(0, 2));
      else
        step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
